acc_operand_stage: RTL and testbench

//  Upstream stage of adder_subtractor in the BIP datapath. Accepts one decoded instruction per

---
 rtl/acc_operand_stage.sv | 144 ++++++++++++++
 tb/tb_acc_operand_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_operand_stage.sv
// Accumulator/operand stage ahead of the BIP adder_subtractor.
// It takes one decoded instruction per handshake and fetches any memory operand.
// It presents ACC/SelB/Op to the combinational adder and owns the accumulator.
// It also handles STO and HLT.
module acc_operand_stage #(
  parameter int unsigned NBITS        = 16,
  parameter int unsigned OPCODE_BITS  = 5,
  parameter int unsigned OPERAND_BITS = 11
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [OPCODE_BITS-1:0]  i_opcode,
  input  logic [OPERAND_BITS-1:0] i_operand,
  output logic                    o_mem_rd_en,
  output logic                    o_mem_wr_en,
  output logic [OPERAND_BITS-1:0] o_mem_addr,
  output logic [NBITS-1:0]        o_mem_wr_data,
  input  logic                    i_mem_rd_valid,
  input  logic [NBITS-1:0]        i_mem_rd_data,
  output logic [NBITS-1:0]        o_ACC,
  output logic [NBITS-1:0]        o_SelB,
  output logic                    o_Op,
  input  logic [NBITS-1:0]        i_Result,
  output logic [NBITS-1:0]        o_acc,
  output logic                    o_done,
  output logic                    o_halted
);

  localparam int unsigned EXT_BITS = NBITS - OPERAND_BITS;

  localparam logic [OPCODE_BITS-1:0] OP_HLT  = OPCODE_BITS'(0);
  localparam logic [OPCODE_BITS-1:0] OP_STO  = OPCODE_BITS'(1);
  localparam logic [OPCODE_BITS-1:0] OP_LD   = OPCODE_BITS'(2);
  localparam logic [OPCODE_BITS-1:0] OP_LDI  = OPCODE_BITS'(3);
  localparam logic [OPCODE_BITS-1:0] OP_ADD  = OPCODE_BITS'(4);
  localparam logic [OPCODE_BITS-1:0] OP_ADDI = OPCODE_BITS'(5);
  localparam logic [OPCODE_BITS-1:0] OP_SUB  = OPCODE_BITS'(6);
  localparam logic [OPCODE_BITS-1:0] OP_SUBI = OPCODE_BITS'(7);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEM_REQ  = 3'd1,
    S_MEM_WAIT = 3'd2,
    S_EXEC     = 3'd3,
    S_HALT     = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [OPCODE_BITS-1:0]  opcode_q, opcode_d;
  logic [OPERAND_BITS-1:0] operand_q, operand_d;
  logic [NBITS-1:0]        mem_data_q, mem_data_d;
  logic [NBITS-1:0]        acc_q, acc_d;
  logic                    halt_entry_q, halt_entry_d;
  logic [NBITS-1:0]        imm_sext;

  assign imm_sext = {{EXT_BITS{operand_q[OPERAND_BITS-1]}}, operand_q};

  // State, latched instruction, memory operand and accumulator registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      opcode_q     <= '0;
      operand_q    <= '0;
      mem_data_q   <= '0;
      acc_q        <= '0;
      halt_entry_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      operand_q    <= operand_d;
      mem_data_q   <= mem_data_d;
      acc_q        <= acc_d;
      halt_entry_q <= halt_entry_d;
    end
  end

  // Next-state, instruction latch and accumulator update
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    operand_d    = operand_q;
    mem_data_d   = mem_data_q;
    acc_d        = acc_q;
    halt_entry_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          opcode_d  = i_opcode;
          operand_d = i_operand;
          case (i_opcode)
            OP_LD, OP_ADD, OP_SUB: state_d = S_MEM_REQ;
            OP_HLT: begin
              state_d      = S_HALT;
              halt_entry_d = 1'b1;
            end
            default: state_d = S_EXEC;
          endcase
        end
      end
      S_MEM_REQ: state_d = S_MEM_WAIT;
      S_MEM_WAIT: begin
        if (i_mem_rd_valid) begin
          mem_data_d = i_mem_rd_data;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        case (opcode_q)
          OP_LD:                             acc_d = mem_data_q;
          OP_LDI:                            acc_d = imm_sext;
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI:  acc_d = i_Result;
          default:                           acc_d = acc_q;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Adder B operand: immediate, memory data or zero depending on the opcode
  always_comb begin
    o_SelB = '0;
    case (opcode_q)
      OP_ADDI, OP_SUBI, OP_LDI: o_SelB = imm_sext;
      OP_ADD, OP_SUB, OP_LD:    o_SelB = mem_data_q;
      default:                  o_SelB = '0;
    endcase
  end

  assign o_Op          = (opcode_q == OP_SUB) || (opcode_q == OP_SUBI);
  assign o_ready       = (state_q == S_IDLE);
  assign o_mem_rd_en   = (state_q == S_MEM_REQ);
  assign o_mem_wr_en   = (state_q == S_EXEC) && (opcode_q == OP_STO);
  assign o_mem_addr    = operand_q;
  assign o_mem_wr_data = acc_q;
  assign o_ACC         = acc_q;
  assign o_acc         = acc_q;
  assign o_done        = (state_q == S_EXEC) || ((state_q == S_HALT) && halt_entry_q);
  assign o_halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_acc_operand_stage.sv
// Directed bench for acc_operand_stage with an adder model and a latency-programmable memory.
module tb_acc_operand_stage;

  logic        clk;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_opcode;
  logic [10:0] i_operand;
  logic        o_mem_rd_en;
  logic        o_mem_wr_en;
  logic [10:0] o_mem_addr;
  logic [15:0] o_mem_wr_data;
  logic        i_mem_rd_valid;
  logic [15:0] i_mem_rd_data;
  logic [15:0] o_ACC;
  logic [15:0] o_SelB;
  logic        o_Op;
  logic [15:0] i_Result;
  logic [15:0] o_acc;
  logic        o_done;
  logic        o_halted;

  acc_operand_stage dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_opcode       (i_opcode),
    .i_operand      (i_operand),
    .o_mem_rd_en    (o_mem_rd_en),
    .o_mem_wr_en    (o_mem_wr_en),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wr_data  (o_mem_wr_data),
    .i_mem_rd_valid (i_mem_rd_valid),
    .i_mem_rd_data  (i_mem_rd_data),
    .o_ACC          (o_ACC),
    .o_SelB         (o_SelB),
    .o_Op           (o_Op),
    .i_Result       (i_Result),
    .o_acc          (o_acc),
    .o_done         (o_done),
    .o_halted       (o_halted)
  );

  localparam logic [4:0] HLT = 5'd0, STO = 5'd1, LD = 5'd2, LDI = 5'd3;
  localparam logic [4:0] ADD = 5'd4, ADDI = 5'd5, SUB = 5'd6, SUBI = 5'd7;

  // Combinational adder_subtractor stand-in
  assign i_Result = o_Op ? (o_ACC - o_SelB) : (o_ACC + o_SelB);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder plus a manual override used for stray read-valid pulses
  logic [15:0] mem [0:2047];
  logic        mem_auto;
  int          rd_lat;
  logic        auto_valid, man_valid;
  logic [15:0] auto_data, man_data;
  assign i_mem_rd_valid = auto_valid | man_valid;
  assign i_mem_rd_data  = man_valid ? man_data : auto_data;

  initial begin
    logic [10:0] a;
    auto_valid = 1'b0;
    auto_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_auto && o_mem_rd_en) begin
        a = o_mem_addr;
        repeat (rd_lat) @(negedge clk);
        auto_data  = mem[a];
        auto_valid = 1'b1;
        @(negedge clk);
        auto_valid = 1'b0;
      end
    end
  end

  int rd_cnt = 0;
  int wr_cnt = 0;
  always @(negedge clk) begin
    if (o_mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (o_mem_wr_en) wr_cnt <= wr_cnt + 1;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic issue(input logic [4:0] opc, input logic [10:0] opr);
    i_valid   = 1'b1;
    i_opcode  = opc;
    i_operand = opr;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  typedef struct {
    logic [4:0]  opc;
    logic [10:0] opr;
    logic [15:0] memv;
    int          lat;
    logic [15:0] acc;
    logic [15:0] selb;
    logic        op;
    logic        wr;
  } vec_t;

  vec_t tbl [14];

  initial begin
    bit ok;
    int rd0, wr0;
    logic [15:0] hold;
    logic is_mem;

    tbl[0]  = '{LDI,    11'h3FF, 16'h0000, 0, 16'h03FF, 16'h03FF, 1'b0, 1'b0};
    tbl[1]  = '{ADDI,   11'h001, 16'h0000, 0, 16'h0400, 16'h0001, 1'b0, 1'b0};
    tbl[2]  = '{LDI,    11'h400, 16'h0000, 0, 16'hFC00, 16'hFC00, 1'b0, 1'b0};
    tbl[3]  = '{SUBI,   11'h001, 16'h0000, 0, 16'hFBFF, 16'h0001, 1'b1, 1'b0};
    tbl[4]  = '{LD,     11'h005, 16'h1234, 3, 16'h1234, 16'h1234, 1'b0, 1'b0};
    tbl[5]  = '{LDI,    11'h7FF, 16'h0000, 0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    tbl[6]  = '{ADD,    11'h002, 16'h0001, 1, 16'h0000, 16'h0001, 1'b0, 1'b0};
    tbl[7]  = '{STO,    11'h009, 16'h0000, 0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[8]  = '{LDI,    11'h055, 16'h0000, 0, 16'h0055, 16'h0055, 1'b0, 1'b0};
    tbl[9]  = '{SUB,    11'h007, 16'h0100, 2, 16'hFF55, 16'h0100, 1'b1, 1'b0};
    tbl[10] = '{5'd9,   11'h003, 16'h0000, 0, 16'hFF55, 16'h0000, 1'b0, 1'b0};
    tbl[11] = '{STO,    11'h00A, 16'h0000, 0, 16'hFF55, 16'h0000, 1'b0, 1'b1};
    tbl[12] = '{ADDI,   11'h400, 16'h0000, 0, 16'hFB55, 16'hFC00, 1'b0, 1'b0};
    tbl[13] = '{SUBI,   11'h7FF, 16'h0000, 0, 16'hFB56, 16'hFFFF, 1'b1, 1'b0};

    i_reset   = 1'b1;
    i_valid   = 1'b0;
    i_opcode  = '0;
    i_operand = '0;
    mem_auto  = 1'b1;
    rd_lat    = 1;
    man_valid = 1'b0;
    man_data  = '0;

    // Reset values
    #12;
    chk("rst_acc",    32'(o_acc), 32'h0);
    chk("rst_done",   32'(o_done), 32'h0);
    chk("rst_halted", 32'(o_halted), 32'h0);
    chk("rst_rd_en",  32'(o_mem_rd_en), 32'h0);
    chk("rst_wr_en",  32'(o_mem_wr_en), 32'h0);
    @(negedge clk);
    i_reset = 1'b0;
    #1;
    chk("rst_ready", 32'(o_ready), 32'h1);
    @(negedge clk);

    // Reset during MEM_WAIT abandons the load; a late read-valid is ignored
    issue(LDI, 11'h123);
    wait_done(ok);
    chk("pre_done", 32'(ok), 32'h1);
    @(negedge clk);
    chk("pre_acc", 32'(o_acc), 32'h0123);
    mem_auto = 1'b0;
    wr0 = wr_cnt;
    issue(LD, 11'h003);
    @(negedge clk);
    chk("mr_rd_en", 32'(o_mem_rd_en), 32'h1);
    @(negedge clk);
    chk("mw_ready", 32'(o_ready), 32'h0);
    chk("mw_rd_en", 32'(o_mem_rd_en), 32'h0);
    #2 i_reset = 1'b1;
    #1;
    chk("mid_rst_acc",   32'(o_acc), 32'h0);
    chk("mid_rst_ready", 32'(o_ready), 32'h1);
    chk("mid_rst_wr",    32'(o_mem_wr_en), 32'h0);
    @(negedge clk);
    i_reset   = 1'b0;
    man_data  = 16'hBEEF;
    man_valid = 1'b1;
    @(negedge clk);
    man_valid = 1'b0;
    chk("late_rv_ready", 32'(o_ready), 32'h1);
    chk("late_rv_done",  32'(o_done), 32'h0);
    chk("late_rv_acc",   32'(o_acc), 32'h0);
    @(negedge clk);
    chk("late_rv_acc2",  32'(o_acc), 32'h0);
    chk("mid_rst_nowr",  32'(wr_cnt - wr0), 32'h0);
    mem_auto = 1'b1;

    // Instruction table
    for (int k = 0; k < 14; k++) begin
      is_mem = (tbl[k].opc == LD) || (tbl[k].opc == ADD) || (tbl[k].opc == SUB);
      if (is_mem) begin
        mem[tbl[k].opr] = tbl[k].memv;
        rd_lat = tbl[k].lat;
      end
      rd0 = rd_cnt;
      chk($sformatf("v%0d_ready", k), 32'(o_ready), 32'h1);
      issue(tbl[k].opc, tbl[k].opr);
      wait_done(ok);
      chk($sformatf("v%0d_done", k), 32'(ok), 32'h1);
      chk($sformatf("v%0d_selb", k), 32'(o_SelB), 32'(tbl[k].selb));
      chk($sformatf("v%0d_op", k), 32'(o_Op), 32'(tbl[k].op));
      chk($sformatf("v%0d_wr_en", k), 32'(o_mem_wr_en), 32'(tbl[k].wr));
      chk($sformatf("v%0d_addr", k), 32'(o_mem_addr), 32'(tbl[k].opr));
      if (tbl[k].wr) chk($sformatf("v%0d_wr_data", k), 32'(o_mem_wr_data), 32'(tbl[k - 1].acc));
      @(negedge clk);
      chk($sformatf("v%0d_acc", k), 32'(o_acc), 32'(tbl[k].acc));
      chk($sformatf("v%0d_ACC", k), 32'(o_ACC), 32'(tbl[k].acc));
      chk($sformatf("v%0d_done_low", k), 32'(o_done), 32'h0);
      chk($sformatf("v%0d_rd_cnt", k), 32'(rd_cnt - rd0), is_mem ? 32'h1 : 32'h0);
    end

    // HLT with i_valid held high afterwards
    hold = tbl[13].acc;
    i_valid   = 1'b1;
    i_opcode  = HLT;
    i_operand = '0;
    @(posedge clk);
    #1;
    i_opcode  = LDI;
    i_operand = 11'h001;
    @(negedge clk);
    chk("hlt_halted", 32'(o_halted), 32'h1);
    chk("hlt_done",   32'(o_done), 32'h1);
    chk("hlt_ready",  32'(o_ready), 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("hlt%0d_done", c),   32'(o_done), 32'h0);
      chk($sformatf("hlt%0d_halted", c), 32'(o_halted), 32'h1);
      chk($sformatf("hlt%0d_ready", c),  32'(o_ready), 32'h0);
      chk($sformatf("hlt%0d_acc", c),    32'(o_acc), 32'(hold));
    end
    i_reset = 1'b1;
    i_valid = 1'b0;
    #1;
    chk("hlt_rst_halted", 32'(o_halted), 32'h0);
    chk("hlt_rst_acc",    32'(o_acc), 32'h0);
    @(negedge clk);
    i_reset = 1'b0;
    #1;
    chk("hlt_rst_ready",  32'(o_ready), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
